// File: rtl/shift_tx_if.sv
// Handshake and serial-output bundle for the parallel-to-serial transmitter.
// The word producer uses the master side and the transmitter uses the slave side.
interface shift_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in;
    logic                  in_ready;
    logic                  sout;
    logic                  sstrobe;
    logic                  done;

    modport master (
        output in_valid,
        output in,
        input  in_ready,
        input  sout,
        input  sstrobe,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in,
        output in_ready,
        output sout,
        output sstrobe,
        output done
    );
endinterface

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter feeding the general-purpose register's serial load path.
// A word is taken over a valid/ready handshake and sent LSB first. Each bit is held for
// BIT_CYCLES clocks and strobed in the last of them. All outputs decode registered state only.
module shift_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int HIGH       = DATA_WIDTH - 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cl,
    shift_tx_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(BIT_CYCLES - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [HIGH:0]    shreg;
    logic [CNT_W-1:0] bitcnt;
    logic [DIV_W-1:0] divcnt;

    logic strobe;
    logic last;

    // The strobe marks the final cycle of a bit period; done is the strobe of the last bit.
    always_comb begin
        strobe = (state == SHIFT) && (divcnt == LAST_DIV);
        last   = strobe && (bitcnt == LAST_BIT);
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.sout     = (state == SHIFT) & shreg[0];
    assign bus.sstrobe  = strobe;
    assign bus.done     = last;

    // Handshake capture, bit timing and shifting; an abort clears the counters but leaves shreg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            divcnt <= '0;
        end else if (cl) begin
            state  <= IDLE;
            bitcnt <= '0;
            divcnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg  <= bus.in;
                        bitcnt <= '0;
                        divcnt <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        divcnt <= '0;
                        shreg  <= {1'b0, shreg[HIGH:1]};
                        if (last) begin
                            state <= IDLE;
                        end else begin
                            bitcnt <= bitcnt + CNT_W'(1);
                        end
                    end else begin
                        divcnt <= divcnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_tx.sv
// Self-checking bench for shift_tx: one instance with one clock per bit, one with three.
// Expected serial bits and received words are queued when a word is offered and popped
// as the transmitter strobes them out or completes a word.
module tb_shift_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cl1   = 1'b0;
    logic cl3   = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    logic        bitq[$];
    logic [15:0] wordq[$];

    logic [15:0] rxreg;
    logic        rx_clr = 1'b0;

    shift_tx_if #(.DATA_WIDTH(16)) b1 ();
    shift_tx_if #(.DATA_WIDTH(16)) b3 ();

    shift_tx #(.DATA_WIDTH(16), .HIGH(15), .BIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (cl1),
        .bus   (b1)
    );

    shift_tx #(.DATA_WIDTH(16), .HIGH(15), .BIT_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (cl3),
        .bus   (b3)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Receiving register: sout into the MSB on each strobe, so the first bit ends in bit 0.
    always @(posedge clk) begin
        if (rx_clr)
            rxreg <= 16'h0000;
        else if (b1.sstrobe)
            rxreg <= {b1.sout, rxreg[15:1]};
    end

    // Safety net so the run always ends even if the design stalls somewhere unexpected.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        b1.in_valid = 1'b0;
        b1.in       = 16'h0000;
        b3.in_valid = 1'b0;
        b3.in       = 16'h0000;
        rst_n       = 1'b0;
        #2;
        vectors++;
        if ({b1.in_ready, b1.sout, b1.sstrobe, b1.done} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_dut1: got %b, expected 1000",
                     {b1.in_ready, b1.sout, b1.sstrobe, b1.done});
        end
        vectors++;
        if ({b3.in_ready, b3.sout, b3.sstrobe, b3.done} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_dut3: got %b, expected 1000",
                     {b3.in_ready, b3.sout, b3.sstrobe, b3.done});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({b1.in_ready, b1.sout, b1.sstrobe, b1.done} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %b, expected 1000",
                     {b1.in_ready, b1.sout, b1.sstrobe, b1.done});
        end
    endtask

    task automatic test_basic(input logic [15:0] w, input string name);
        logic exp;
        @(negedge clk);
        vectors++;
        if (b1.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_ready_before: got %b, expected 1", name, b1.in_ready);
        end
        b1.in_valid = 1'b1;
        b1.in       = w;
        for (int k = 0; k < 16; k++) bitq.push_back(w[k]);
        @(negedge clk);
        b1.in_valid = 1'b0;
        b1.in       = ~w;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({b1.sstrobe, b1.done, b1.in_ready} !== {1'b1, 1'(i == 15), 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL %s_ctl[%0d]: got strobe/done/ready %b, expected %b",
                         name, i, {b1.sstrobe, b1.done, b1.in_ready}, {1'b1, 1'(i == 15), 1'b0});
            end
            if (b1.sstrobe && bitq.size() > 0) begin
                exp = bitq.pop_front();
                vectors++;
                if (b1.sout !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL %s_sout[%0d]: got %b, expected %b", name, i, b1.sout, exp);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if ({b1.in_ready, b1.sstrobe, b1.done, 5'(bitq.size())} !== {3'b100, 5'd0}) begin
            miscompares++;
            $display("[TB] FAIL %s_end: got ready/strobe/done %b left %0d, expected 100 left 0",
                     name, {b1.in_ready, b1.sstrobe, b1.done}, bitq.size());
        end
        bitq.delete();
    endtask

    task automatic test_loopback();
        logic [15:0] words[2];
        logic [15:0] exp;
        words[0] = 16'h8001;
        words[1] = 16'h7FFE;
        @(negedge clk);
        rx_clr = 1'b1;
        @(negedge clk);
        rx_clr = 1'b0;
        vectors++;
        if (rxreg !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL loop_clear: got %h, expected 0000", rxreg);
        end
        for (int n = 0; n < 2; n++) begin
            b1.in_valid = 1'b1;
            b1.in       = words[n];
            wordq.push_back(words[n]);
            @(negedge clk);
            b1.in_valid = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (i == 15) begin
                    vectors++;
                    if (b1.done !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL loop_done[%0d]: got %b, expected 1", n, b1.done);
                    end
                end
                @(negedge clk);
            end
            exp = wordq.pop_front();
            vectors++;
            if (rxreg !== exp) begin
                miscompares++;
                $display("[TB] FAIL loop_word[%0d]: got %h, expected %h", n, rxreg, exp);
            end
        end
    endtask

    task automatic test_bit_spacing();
        @(negedge clk);
        b3.in_valid = 1'b1;
        b3.in       = 16'h0001;
        @(negedge clk);
        b3.in_valid = 1'b0;
        for (int c = 0; c < 48; c++) begin
            vectors++;
            if ({b3.sout, b3.sstrobe, b3.done, b3.in_ready} !==
                {1'(c < 3), 1'(c % 3 == 2), 1'(c == 47), 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL spacing[%0d]: got sout/strobe/done/ready %b, expected %b", c,
                         {b3.sout, b3.sstrobe, b3.done, b3.in_ready},
                         {1'(c < 3), 1'(c % 3 == 2), 1'(c == 47), 1'b0});
            end
            @(negedge clk);
        end
        vectors++;
        if ({b3.in_ready, b3.sstrobe, b3.done} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL spacing_end: got %b, expected 100",
                     {b3.in_ready, b3.sstrobe, b3.done});
        end
    endtask

    task automatic test_back_to_back();
        int   n0   = -1;
        int   n1   = -1;
        int   nacc = 0;
        logic exp;
        @(negedge clk);
        b1.in_valid = 1'b1;
        b1.in       = 16'hFFFF;
        for (int n = 0; n < 45; n++) begin
            if (b1.sstrobe) begin
                vectors++;
                if (bitq.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_extra_strobe[%0d]: got strobe 1, expected 0", n);
                end else begin
                    exp = bitq.pop_front();
                    if (b1.sout !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_sout[%0d]: got %b, expected %b", n, b1.sout, exp);
                    end
                end
            end
            if (b1.in_ready && b1.in_valid) begin
                if (nacc == 0) begin
                    n0 = n;
                    for (int k = 0; k < 16; k++) bitq.push_back(1'b1);
                end else if (nacc == 1) begin
                    n1 = n;
                    for (int k = 0; k < 16; k++) bitq.push_back(1'b0);
                end
                nacc++;
            end
            if (nacc == 1 && n > n0) b1.in = 16'h0000;
            if (nacc >= 2 && n > n1) b1.in_valid = 1'b0;
            @(negedge clk);
        end
        b1.in_valid = 1'b0;
        vectors++;
        if (nacc !== 2 || (n1 - n0) !== 17) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing: got %0d accepts %0d apart, expected 2 accepts 17 apart",
                     nacc, n1 - n0);
        end
        vectors++;
        if (bitq.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_bits_left: got %0d, expected 0", bitq.size());
        end
        bitq.delete();
    endtask

    task automatic test_abort();
        logic [15:0] w = 16'h1234;
        logic        exp;
        @(negedge clk);
        b1.in_valid = 1'b1;
        b1.in       = w;
        for (int k = 0; k < 5; k++) bitq.push_back(w[k]);
        @(negedge clk);
        b1.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({b1.sstrobe, b1.done} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL abort_ctl[%0d]: got strobe/done %b, expected 10",
                         i, {b1.sstrobe, b1.done});
            end
            if (bitq.size() > 0) begin
                exp = bitq.pop_front();
                vectors++;
                if (b1.sout !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL abort_sout[%0d]: got %b, expected %b", i, b1.sout, exp);
                end
            end
            if (i == 4) cl1 = 1'b1;
            @(negedge clk);
        end
        cl1 = 1'b0;
        vectors++;
        if ({b1.in_ready, b1.sstrobe, b1.done, b1.sout} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got ready/strobe/done/sout %b, expected 1000",
                     {b1.in_ready, b1.sstrobe, b1.done, b1.sout});
        end
        bitq.delete();
        test_basic_after_abort();
    endtask

    task automatic test_basic_after_abort();
        logic [15:0] w = 16'h00FF;
        logic        exp;
        b1.in_valid = 1'b1;
        b1.in       = w;
        for (int k = 0; k < 16; k++) bitq.push_back(w[k]);
        @(negedge clk);
        b1.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({b1.sstrobe, b1.done} !== {1'b1, 1'(i == 15)}) begin
                miscompares++;
                $display("[TB] FAIL post_abort_ctl[%0d]: got strobe/done %b, expected %b",
                         i, {b1.sstrobe, b1.done}, {1'b1, 1'(i == 15)});
            end
            if (b1.sstrobe && bitq.size() > 0) begin
                exp = bitq.pop_front();
                vectors++;
                if (b1.sout !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL post_abort_sout[%0d]: got %b, expected %b", i, b1.sout, exp);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if ({b1.in_ready, 5'(bitq.size())} !== {1'b1, 5'd0}) begin
            miscompares++;
            $display("[TB] FAIL post_abort_end: got ready %b left %0d, expected 1 left 0",
                     b1.in_ready, bitq.size());
        end
        bitq.delete();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        b1.in_valid = 1'b1;
        b1.in       = 16'hBEEF;
        @(negedge clk);
        b1.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({b1.in_ready, b1.sout, b1.sstrobe, b1.done} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %b, expected 1000",
                     {b1.in_ready, b1.sout, b1.sstrobe, b1.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({b1.in_ready, b1.sstrobe, b1.done} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL after_reset_quiet[%0d]: got %b, expected 100",
                         i, {b1.in_ready, b1.sstrobe, b1.done});
            end
        end
        test_basic(16'hBEEF, "beef");
    endtask

    initial begin
        test_reset();
        test_basic(16'hA5C3, "basic");
        test_loopback();
        test_bit_spacing();
        test_back_to_back();
        test_abort();
        test_async_reset();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
